// File: rtl/piso_serializer_if.sv
// piso_serializer_if: valid/ready word handshake into the serializer.
// The master presents a word; the slave signals when it can take one.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready input.
// Each bit is held BIT_CYCLES clocks; frame brackets the data bits.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_serializer_if.slave in_if,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic [CW-1:0]    cyc_cnt;
    logic [CW-1:0]    cyc_cnt_nxt;
    logic             serial_nxt;
    logic             frame_nxt;
    logic             done_nxt;
    logic             accept;

    assign in_if.in_ready = (state == IDLE);
    assign accept         = in_if.in_valid && (state == IDLE);

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit in send order into the output position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        bit_cnt_nxt = bit_cnt;
        cyc_cnt_nxt = cyc_cnt;
        serial_nxt  = serial_out;
        frame_nxt   = frame;
        done_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = SHIFT;
                    sreg_nxt    = in_if.in_data;
                    bit_cnt_nxt = BIT_LAST;
                    cyc_cnt_nxt = CYC_LAST;
                    serial_nxt  = head_bit(in_if.in_data);
                    frame_nxt   = 1'b1;
                end
            end
            SHIFT: begin
                if (cyc_cnt != '0) begin
                    cyc_cnt_nxt = cyc_cnt - 1'b1;
                end else if (bit_cnt != '0) begin
                    sreg_nxt    = advance(sreg);
                    serial_nxt  = head_bit(advance(sreg));
                    bit_cnt_nxt = bit_cnt - 1'b1;
                    cyc_cnt_nxt = CYC_LAST;
                end else begin
                    state_nxt  = IDLE;
                    serial_nxt = 1'b0;
                    frame_nxt  = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            serial_out <= 1'b0;
            frame      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            cyc_cnt    <= cyc_cnt_nxt;
            serial_out <= serial_nxt;
            frame      <= frame_nxt;
            done       <= done_nxt;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: three configurations share one stimulus stream;
// a bit-queue model predicts every output cycle for each of them.
module tb_piso_serializer;
    localparam int W  = 8;
    localparam int ND = 3;
    localparam int BC [ND] = '{1, 3, 1};
    localparam bit MF [ND] = '{1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic so;
        logic fr;
        logic dn;
        logic rdy;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          vld;
    logic [W-1:0]  dat;
    logic [ND-1:0] so;
    logic [ND-1:0] fr;
    logic [ND-1:0] dn;
    logic [ND-1:0] rdy;
    logic [W-1:0]  sipo;
    logic [W-1:0]  last0;

    exp_t expq [ND][$];
    bit   bits [ND][$];
    int   n_chk;
    int   n_fail;

    piso_serializer_if #(.WIDTH(W)) if0 ();
    piso_serializer_if #(.WIDTH(W)) if1 ();
    piso_serializer_if #(.WIDTH(W)) if2 ();

    assign if0.in_valid = vld;
    assign if0.in_data  = dat;
    assign if1.in_valid = vld;
    assign if1.in_data  = dat;
    assign if2.in_valid = vld;
    assign if2.in_data  = dat;
    assign rdy = {if2.in_ready, if1.in_ready, if0.in_ready};

    piso_serializer #(.WIDTH(W), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_if(if0),
        .serial_out(so[0]), .frame(fr[0]), .done(dn[0])
    );
    piso_serializer #(.WIDTH(W), .BIT_CYCLES(3), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_if(if1),
        .serial_out(so[1]), .frame(fr[1]), .done(dn[1])
    );
    piso_serializer #(.WIDTH(W), .BIT_CYCLES(1), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_if(if2),
        .serial_out(so[2]), .frame(fr[2]), .done(dn[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiver-side shift register fed by the MSB-first, 1-cycle stream.
    always @(posedge clk) sipo <= {sipo[W-2:0], so[0]};

    // Front of bits[d] is the bit on the wire now; empty means idle.
    task automatic model_step(input int d);
        exp_t e;
        if (bits[d].size() != 0) begin
            bits[d].delete(0);
            if (bits[d].size() == 0)
                e = '{so: 1'b0, fr: 1'b0, dn: 1'b1, rdy: 1'b1};
            else
                e = '{so: bits[d][0], fr: 1'b1, dn: 1'b0, rdy: 1'b0};
        end else if (vld) begin
            for (int k = 0; k < W; k++) begin
                int idx;
                idx = MF[d] ? (W - 1 - k) : k;
                for (int c = 0; c < BC[d]; c++) bits[d].push_back(dat[idx]);
            end
            if (d == 0) last0 = dat;
            e = '{so: bits[d][0], fr: 1'b1, dn: 1'b0, rdy: 1'b0};
        end else begin
            e = '{so: 1'b0, fr: 1'b0, dn: 1'b0, rdy: 1'b1};
        end
        expq[d].push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int d = 0; d < ND; d++) bits[d].delete();
            end else begin
                for (int d = 0; d < ND; d++) model_step(d);
            end
        end
    end

    initial begin
        exp_t e;
        logic [3:0] got;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                if (expq[d].size() != 0) begin
                    e   = expq[d].pop_front();
                    got = {so[d], fr[d], dn[d], rdy[d]};
                    n_chk++;
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL out_dut%0d t=%0t so/fr/dn/rdy got %b want %b",
                                 d, $time, got, e);
                    end
                    if (d == 0 && e.dn) begin
                        n_chk++;
                        if (sipo !== last0) begin
                            n_fail++;
                            $display("FAIL sipo t=%0t got %h want %h",
                                     $time, sipo, last0);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, got, want);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_so"},  {5'd0, so},  8'h00);
        chk({tag, "_fr"},  {5'd0, fr},  8'h00);
        chk({tag, "_dn"},  {5'd0, dn},  8'h00);
        chk({tag, "_rdy"}, {5'd0, rdy}, 8'h07);
    endtask

    task automatic send(input logic [W-1:0] w);
        @(negedge clk);
        vld = 1'b1;
        dat = w;
        @(negedge clk);
        vld = 1'b0;
        dat = W'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        vld    = 1'b0;
        dat    = '0;
        last0  = '0;
        #3;
        chk_reset_outputs("reset");
        gap(2);
        rst_n = 1'b1;

        send(8'hA5);
        gap(30);
        send(8'h3C);
        gap(30);
        send(8'h81);
        gap(30);
        send(8'h01);
        gap(30);

        @(negedge clk);
        vld = 1'b1;
        dat = 8'h12;
        @(negedge clk);
        dat = 8'h34;
        gap(10);
        vld = 1'b0;
        dat = 8'hC3;
        gap(60);

        send(8'hFF);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk_reset_outputs("heldrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", {5'd0, rdy}, 8'h07);
        send(8'h0F);
        gap(30);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            vld = ($urandom_range(0, 3) == 0);
            dat = W'($urandom);
        end
        vld = 1'b0;
        gap(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
